// File: rtl/cmd_encoder_if.sv
// rtl/cmd_encoder_if.sv - instruction-in / command-out handshake bundle for cmd_encoder
// Optional illegal_cnt member exists only with CMD_ENC_ILLEGAL_CNT_EN defined.
interface cmd_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  command;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [25:0] imm;
    logic        illegal;
`ifdef CMD_ENC_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, command, rs, rt, rd, imm, illegal
`ifdef CMD_ENC_ILLEGAL_CNT_EN
        , input illegal_cnt
`endif
    );

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, command, rs, rt, rd, imm, illegal
`ifdef CMD_ENC_ILLEGAL_CNT_EN
        , output illegal_cnt
`endif
    );
endinterface

// File: rtl/cmd_encoder.sv
// rtl/cmd_encoder.sv - MIPS word to control-decoder command encoder with one-entry output buffer
// CMD_ENC_ILLEGAL_CNT_EN adds a saturating 16-bit count of accepted illegal words.
module cmd_encoder (
    input  logic          clk,
    input  logic          rst_n,
    cmd_encoder_if.slave  bus
);
    logic        valid_q, valid_d;
    logic [4:0]  cmd_q, cmd_d;
    logic        illegal_q, illegal_d;
    logic [25:0] imm_q, imm_d;

    logic [4:0]  cmd_dec;
    logic        illegal_dec;
    logic        accept;
    logic        consume;
    logic [5:0]  op;
    logic [5:0]  fn;

    assign op = bus.instr[31:26];
    assign fn = bus.instr[5:0];

    always_comb begin
        cmd_dec     = 5'd0;
        illegal_dec = 1'b0;
        if (bus.instr != 32'd0) begin
            case (op)
                6'h00: begin
                    case (fn)
                        6'h20:   cmd_dec = 5'd1;
                        6'h22:   cmd_dec = 5'd2;
                        6'h08:   cmd_dec = 5'd8;
                        default: illegal_dec = 1'b1;
                    endcase
                end
                6'h0D:   cmd_dec = 5'd3;
                6'h23:   cmd_dec = 5'd4;
                6'h2B:   cmd_dec = 5'd5;
                6'h04:   cmd_dec = 5'd6;
                6'h03:   cmd_dec = 5'd7;
                6'h0F:   cmd_dec = 5'd9;
                default: illegal_dec = 1'b1;
            endcase
        end
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign consume      = valid_q && bus.out_ready;

    // Flush wins over accept: the word is dropped and the data regs keep their old contents.
    always_comb begin
        valid_d   = valid_q;
        cmd_d     = cmd_q;
        illegal_d = illegal_q;
        imm_d     = imm_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            cmd_d     = cmd_dec;
            illegal_d = illegal_dec;
            imm_d     = bus.instr[25:0];
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            cmd_q     <= 5'd0;
            illegal_q <= 1'b0;
            imm_q     <= 26'd0;
        end else begin
            valid_q   <= valid_d;
            cmd_q     <= cmd_d;
            illegal_q <= illegal_d;
            imm_q     <= imm_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.command   = cmd_q;
    assign bus.illegal   = illegal_q;
    assign bus.imm       = imm_q;
    assign bus.rs        = imm_q[25:21];
    assign bus.rt        = imm_q[20:16];
    assign bus.rd        = imm_q[15:11];

`ifdef CMD_ENC_ILLEGAL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counts at accept regardless of flush, so dropped illegal words are still visible.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && illegal_dec && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.illegal_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_cmd_encoder.sv
// tb/tb_cmd_encoder.sv - directed self-checking bench for cmd_encoder
module tb_cmd_encoder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_cnt;

    cmd_encoder_if bus ();

    cmd_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  cmd;
        logic        ill;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
`ifdef CMD_ENC_ILLEGAL_CNT_EN
        check(tag, {16'd0, bus.illegal_cnt}, exp_cnt);
`endif
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;
        vecs[0] = '{32'h00000000, 5'd0, 1'b0};
        vecs[1] = '{32'h00851022, 5'd2, 1'b0};
        vecs[2] = '{32'h3421FFFF, 5'd3, 1'b0};
        vecs[3] = '{32'h10220003, 5'd6, 1'b0};
        vecs[4] = '{32'h03E00008, 5'd8, 1'b0};
        vecs[5] = '{32'h00000009, 5'd0, 1'b1};
        vecs[6] = '{32'hFC000000, 5'd0, 1'b1};
        vecs[7] = '{32'h00000020, 5'd1, 1'b0};
        vecs[8] = '{32'h03E00009, 5'd0, 1'b1};
        vecs[9] = '{32'hAC000000, 5'd5, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = 32'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_command", {27'd0, bus.command}, 32'd0);
        check("rst_imm", {6'd0, bus.imm}, 32'd0);
        check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        check_cnt("rst_cnt");
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // add $8,$9,$10
        bus.in_valid = 1'b1;
        bus.instr    = 32'h012A4020;
        tick();
        bus.in_valid = 1'b0;
        check("add_valid", {31'd0, bus.out_valid}, 32'd1);
        check("add_cmd", {27'd0, bus.command}, 32'd1);
        check("add_rs", {27'd0, bus.rs}, 32'd9);
        check("add_rt", {27'd0, bus.rt}, 32'd10);
        check("add_rd", {27'd0, bus.rd}, 32'd8);
        check("add_ill", {31'd0, bus.illegal}, 32'd0);
        tick();
        check("add_drained", {31'd0, bus.out_valid}, 32'd0);
        check("add_data_kept", {27'd0, bus.command}, 32'd1);

        // back-to-back lui / lw / jal
        bus.in_valid = 1'b1;
        bus.instr    = 32'h3C01ABCD;
        #1;
        check("s0_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check("s0_cmd", {27'd0, bus.command}, 32'd9);
        check("s0_imm16", {16'd0, bus.imm[15:0]}, 32'h0000ABCD);
        check("s0_rt", {27'd0, bus.rt}, 32'd1);
        bus.instr = 32'h8C220004;
        check("s1_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check("s1_cmd", {27'd0, bus.command}, 32'd4);
        check("s1_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.instr = 32'h0C000010;
        check("s2_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check("s2_cmd", {27'd0, bus.command}, 32'd7);
        check("s2_imm", {6'd0, bus.imm}, 32'h00000010);
        bus.in_valid = 1'b0;
        tick();

        // table sweep at full rate
        foreach (vecs[i]) begin
            bus.in_valid = 1'b1;
            bus.instr    = vecs[i].instr;
            if (vecs[i].ill) exp_cnt++;
            tick();
            check($sformatf("tbl%0d_cmd", i), {27'd0, bus.command}, {27'd0, vecs[i].cmd});
            check($sformatf("tbl%0d_ill", i), {31'd0, bus.illegal}, {31'd0, vecs[i].ill});
            check($sformatf("tbl%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
            check_cnt($sformatf("tbl%0d_cnt", i));
        end
        bus.in_valid = 1'b0;
        tick();

        // backpressure: sw held while out_ready=0, beq waits
        bus.in_valid  = 1'b1;
        bus.instr     = 32'hAC220008;
        bus.out_ready = 1'b0;
        tick();
        bus.instr = 32'h10220003;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d_in_ready", c), {31'd0, bus.in_ready}, 32'd0);
            tick();
            check($sformatf("bp%0d_cmd", c), {27'd0, bus.command}, 32'd5);
            check($sformatf("bp%0d_valid", c), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("bp%0d_imm", c), {6'd0, bus.imm}, 32'h00220008);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_second_cmd", {27'd0, bus.command}, 32'd6);
        check("bp_second_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();
        check("idle_valid", {31'd0, bus.out_valid}, 32'd0);
        check("idle_cmd_kept", {27'd0, bus.command}, 32'd6);

        // flush drops a same-cycle accepted jr, buffer data untouched
        bus.in_valid = 1'b1;
        bus.instr    = 32'h03E00008;
        bus.flush    = 1'b1;
        #1;
        check("fl_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check("fl_valid", {31'd0, bus.out_valid}, 32'd0);
        check("fl_cmd_kept", {27'd0, bus.command}, 32'd6);
        // flush of a buffered word while an illegal word is accepted: still counted
        bus.flush = 1'b0;
        tick();
        check("fl_reload", {27'd0, bus.command}, 32'd8);
        bus.instr = 32'hFC000000;
        bus.flush = 1'b1;
        exp_cnt++;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("fl2_valid", {31'd0, bus.out_valid}, 32'd0);
        check("fl2_ill", {31'd0, bus.illegal}, 32'd0);
        check_cnt("fl2_cnt");

        // async reset with a stalled word in the buffer
        bus.in_valid  = 1'b1;
        bus.instr     = 32'h00000009;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        check("pre_rst_ill", {31'd0, bus.illegal}, 32'd1);
        #2;
        rst_n   = 1'b0;
        exp_cnt = 0;
        #1;
        check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_ill", {31'd0, bus.illegal}, 32'd0);
        check("arst_rs", {27'd0, bus.rs}, 32'd0);
        check("arst_imm", {6'd0, bus.imm}, 32'd0);
        check_cnt("arst_cnt");
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmd_encoder.md
CMD_ENCODER -- requirements
Module: cmd_encoder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, async active-low reset).
REQ-002 SHALL provide in_valid (input, 1): upstream instruction word present.
REQ-003 SHALL provide in_ready (output, 1): block accepts the instruction this cycle.
REQ-004 SHALL provide instr (input, 32): MIPS instruction word.
REQ-005 SHALL provide flush (input, 1): discard the buffered result.
REQ-006 SHALL provide out_valid (output, 1): encoded result available.
REQ-007 SHALL provide out_ready (input, 1): downstream consumes the result.
REQ-008 SHALL provide command (output, 5): command code for the control decoder.
REQ-009 SHALL provide rs, rt, rd (outputs, 5 each): register fields instr[25:21], instr[20:16], instr[15:11].
REQ-010 SHALL provide imm (output, 26): instr[25:0], where the consumer uses [15:0] or all 26 bits.
REQ-011 SHALL provide illegal (output, 1): the buffered word matched no table entry.

Function
REQ-012 SHALL encode the command as follows, where op = instr[31:26] and fn = instr[5:0]:
- instr==0 -> 0 (nop)
- op 0, fn 0x20 -> 1 (add)
- op 0, fn 0x22 -> 2 (sub)
- op 0x0D -> 3 (ori)
- op 0x23 -> 4 (lw)
- op 0x2B -> 5 (sw)
- op 0x04 -> 6 (beq)
- op 0x03 -> 7 (jal)
- op 0, fn 0x08 -> 8 (jr)
- op 0x0F -> 9 (lui)
REQ-013 SHALL encode any other word as command 0 with illegal=1; illegal SHALL be 0 for every table entry, including instr==0.
REQ-014 SHALL register results in a one-entry output buffer with latency exactly 1 cycle from accept to out_valid.
REQ-015 SHALL drive in_ready = !out_valid || out_ready combinationally, so back-to-back transfers run at 1 word/cycle.
REQ-016 SHALL treat accept = in_valid && in_ready and consume = out_valid && out_ready.
REQ-017 SHALL load the buffer and keep out_valid=1 when accept occurs, including on a simultaneous consume.
REQ-018 SHALL clear out_valid when consume occurs without accept.
REQ-019 SHALL hold command, rs, rt, rd, imm and illegal stable while out_valid && !out_ready.
REQ-020 SHALL give flush priority: out_valid=0 next cycle, any same-cycle accepted word is dropped, and in_ready is unaffected by flush.
REQ-021 SHALL not update the buffer while in_valid=0; the data outputs keep their last values.

Reset
REQ-022 SHALL, while rst_n=0, force out_valid=0, command=0, rs=rt=rd=0, imm=0 and illegal=0 asynchronously.
REQ-023 SHALL drive in_ready=1 from reset release.
REQ-024 SHALL discard an in-flight buffered word if reset asserts mid-transfer; it is never presented after reset.

Configuration
REQ-025 SHALL, with CMD_ENC_ILLEGAL_CNT_EN defined:
- add output illegal_cnt (16) that counts accepted words encoded as illegal, including words later flushed;
- saturate the counter at 0xFFFF;
- reset the counter to 0;
- increment the counter one cycle after accept.
REQ-026 SHALL, without CMD_ENC_ILLEGAL_CNT_EN, omit the illegal_cnt port and the counter logic; all other behaviour is identical.

Verification
REQ-027 SHALL cover: instr 0x012A4020 with out_ready=1 -> next cycle out_valid=1, command=1, rs=9, rt=10, rd=8, illegal=0.
REQ-028 SHALL cover: stream 0x3C01ABCD, 0x8C220004, 0x0C000010 on consecutive cycles with out_ready=1 -> commands 9, 4, 7 on consecutive cycles, in_ready constantly 1.
REQ-029 SHALL cover: 0xAC220008 accepted, out_ready=0 for 3 cycles -> command=5 held, in_ready=0, a second word is not accepted until out_ready=1.
REQ-030 SHALL cover: 0x00000009 (op 0, fn 0x09) -> command=0, illegal=1; with CMD_ENC_ILLEGAL_CNT_EN, illegal_cnt=1.
REQ-031 SHALL cover: flush=1 in the same cycle as in_valid with 0x03E00008 -> out_valid=0 next cycle; with out_valid=1 and rst_n pulsed low -> all outputs 0 immediately.
